// File: rtl/regfile_read_port_arbiter.sv
// regfile_read_port_arbiter
// Round-robin arbiter sharing one register-file read port between NUM_REQ
// requesters. ACK is combinational in the grant cycle. The mux select is
// registered one edge later and the read data one edge after that, so the
// response appears two cycles after ACK. One grant per cycle, fully pipelined.
// Optional feature macro: REGFILE_ZERO_REG_EN. When defined, a read of
// register 0 returns zero no matter what the mux drives.
module regfile_read_port_arbiter #(
  parameter int BITS    = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*5-1:0] i_addr,
  input  logic                 i_stall,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [4:0]           o_mux_select,
  input  logic [BITS-1:0]      i_mux_out,
  output logic [NUM_REQ-1:0]   o_resp_valid,
  output logic [BITS-1:0]      o_resp_data,
  output logic                 o_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pointer and pipeline state
  logic [PTR_W-1:0]   r_ptr;
  logic [4:0]         r_mux_select;
  logic               r_s1_valid;
  logic [PTR_W-1:0]   r_s1_owner;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [BITS-1:0]    r_resp_data;

  // Arbitration signals
  logic [4:0]         w_addr     [NUM_REQ];
  logic [PTR_W:0]     w_scan_sum [NUM_REQ];
  logic [PTR_W-1:0]   w_scan_idx [NUM_REQ];
  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic               w_grant;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [NUM_REQ-1:0] w_ack;
  logic [BITS-1:0]    w_rd_next;

  // Unpack per-requester addresses and build the scan order starting at r_ptr.
  // Both r_ptr and gi are below NUM_REQ, so one conditional subtract wraps.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
    assign w_addr[gi]     = i_addr[gi*5 +: 5];
    assign w_scan_sum[gi] = {1'b0, r_ptr} + (PTR_W+1)'(gi);
    assign w_scan_idx[gi] = (w_scan_sum[gi] >= (PTR_W+1)'(NUM_REQ))
                            ? PTR_W'(w_scan_sum[gi] - (PTR_W+1)'(NUM_REQ))
                            : w_scan_sum[gi][PTR_W-1:0];
  end

  // Pick the first requesting index in rotated order from the pointer
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[w_scan_idx[k]]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx[k];
      end
    end
  end

  // Reset and stall both suppress the grant; ACK is one-hot on the winner
  assign w_grant    = w_found && !i_stall && !i_reset;
  assign w_ack      = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
  assign w_ptr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  // Register 0 can be forced to read as zero; r_mux_select is the granted index
`ifdef REGFILE_ZERO_REG_EN
  assign w_rd_next = (r_mux_select == 5'd0) ? '0 : i_mux_out;
`else
  assign w_rd_next = i_mux_out;
`endif

  // Stage 0 -> stage 1: advance pointer, launch the select for the winner
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr        <= '0;
      r_mux_select <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_owner   <= '0;
    end else begin
      r_s1_valid <= w_grant;
      if (w_grant) begin
        r_ptr        <= w_ptr_next;
        r_mux_select <= w_addr[w_winner];
        r_s1_owner   <= w_winner;
      end
    end
  end

  // Stage 1 -> stage 2: capture mux output and tag it with its owner
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= r_s1_valid ? (NUM_REQ'(1) << r_s1_owner) : '0;
      if (r_s1_valid) begin
        r_resp_data <= w_rd_next;
      end
    end
  end

  assign o_ack        = w_ack;
  assign o_mux_select = r_mux_select;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_busy       = r_s1_valid | (|r_resp_valid);

endmodule

// File: tb/tb_regfile_read_port_arbiter.sv
// Directed testbench for regfile_read_port_arbiter (NUM_REQ=4, BITS=32).
// A per-cycle vector table covers single read, contention, wrap, stall,
// reset mid-flight and register 0; hand-written sequences cover rotation
// and the ACK-to-response latency.
module tb_regfile_read_port_arbiter;

  localparam int BITS = 32;
  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [19:0]     addr;
  logic            stall;
  logic [3:0]      ack;
  logic [4:0]      sel;
  logic [31:0]     mux_out;
  logic [3:0]      rv;
  logic [31:0]     rd;
  logic            busy;

  logic [31:0]     regs [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_read_port_arbiter #(.BITS(BITS), .NUM_REQ(NREQ)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req        (req),
    .i_addr       (addr),
    .i_stall      (stall),
    .o_ack        (ack),
    .o_mux_select (sel),
    .i_mux_out    (mux_out),
    .o_resp_valid (rv),
    .o_resp_data  (rd),
    .o_busy       (busy)
  );

  // Combinational register-bank model behind the 32:1 mux
  assign mux_out = regs[sel];

  typedef struct {
    logic        rst;
    logic        stall;
    logic [3:0]  req;
    logic [19:0] addr;
    logic [3:0]  ack;
    logic [4:0]  sel;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        busy;
  } vec_t;

  vec_t vec [64];
  int   nvec = 0;

  localparam logic [19:0] A5   = {5'd13, 5'd12, 5'd11, 5'd5};
  localparam logic [19:0] ASEQ = {5'd13, 5'd12, 5'd11, 5'd10};
  localparam logic [19:0] AZ   = {5'd13, 5'd12, 5'd11, 5'd0};

  localparam logic [31:0] RA = 32'h1000_000A;
  localparam logic [31:0] RB = 32'h1000_000B;
  localparam logic [31:0] RC = 32'h1000_000C;
  localparam logic [31:0] RD = 32'h1000_000D;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
`ifdef REGFILE_ZERO_REG_EN
  localparam logic [31:0] ZEXP = 32'h0000_0000;
`else
  localparam logic [31:0] ZEXP = 32'hFFFF_FFFF;
`endif

  task automatic put(input logic r, input logic s, input logic [3:0] q,
                     input logic [19:0] a, input logic [3:0] e_ack,
                     input logic [4:0] e_sel, input logic [3:0] e_rv,
                     input logic [31:0] e_rd, input logic e_busy);
    vec[nvec] = '{r, s, q, a, e_ack, e_sel, e_rv, e_rd, e_busy};
    nvec++;
  endtask

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp_v);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;

    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[0] = 32'hFFFF_FFFF;
    regs[5] = DB;

    //   rst stl req     addr  ack     sel     rv      rd    busy
    put(1, 0, 4'b1111, ASEQ, 4'b0000, 5'd0,  4'b0000, 0,    0); // ACK forced low in reset
    put(0, 0, 4'b0001, A5,   4'b0001, 5'd0,  4'b0000, 0,    0); // single read
    put(0, 0, 4'b0000, A5,   4'b0000, 5'd5,  4'b0000, 0,    1);
    put(0, 0, 4'b0000, A5,   4'b0000, 5'd5,  4'b0001, DB,   1);
    put(0, 0, 4'b0000, A5,   4'b0000, 5'd5,  4'b0000, DB,   0);
    put(1, 0, 4'b1111, ASEQ, 4'b0000, 5'd5,  4'b0000, DB,   0); // reset -> ptr 0
    put(0, 0, 4'b1111, ASEQ, 4'b0001, 5'd0,  4'b0000, 0,    0); // full contention
    put(0, 0, 4'b1111, ASEQ, 4'b0010, 5'd10, 4'b0000, 0,    1);
    put(0, 0, 4'b1111, ASEQ, 4'b0100, 5'd11, 4'b0001, RA,   1);
    put(0, 0, 4'b1111, ASEQ, 4'b1000, 5'd12, 4'b0010, RB,   1);
    put(0, 0, 4'b1111, ASEQ, 4'b0001, 5'd13, 4'b0100, RC,   1); // wrapped to 0
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd10, 4'b1000, RD,   1);
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd10, 4'b0001, RA,   1);
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd10, 4'b0000, RA,   0); // ptr=1
    put(0, 0, 4'b0110, ASEQ, 4'b0010, 5'd10, 4'b0000, RA,   0); // wrap/fairness
    put(0, 0, 4'b0100, ASEQ, 4'b0100, 5'd11, 4'b0000, RA,   1);
    put(0, 0, 4'b1001, ASEQ, 4'b1000, 5'd12, 4'b0010, RB,   1); // ptr=3 -> grant 3
    put(0, 0, 4'b0001, ASEQ, 4'b0001, 5'd13, 4'b0100, RC,   1); // ptr=0 -> grant 0
    put(0, 0, 4'b1001, ASEQ, 4'b1000, 5'd10, 4'b1000, RD,   1); // ptr=1 -> skips 0
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd13, 4'b0001, RA,   1);
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd13, 4'b1000, RD,   1);
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd13, 4'b0000, RD,   0); // ptr=0
    put(0, 0, 4'b0001, ASEQ, 4'b0001, 5'd13, 4'b0000, RD,   0); // grant before stall
    put(0, 1, 4'b1010, ASEQ, 4'b0000, 5'd10, 4'b0000, RD,   1); // stall, in-flight read
    put(0, 1, 4'b1010, ASEQ, 4'b0000, 5'd10, 4'b0001, RA,   1); // still returns
    put(0, 1, 4'b1010, ASEQ, 4'b0000, 5'd10, 4'b0000, RA,   0);
    put(0, 0, 4'b1010, ASEQ, 4'b0010, 5'd10, 4'b0000, RA,   0); // ptr frozen at 1
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd11, 4'b0000, RA,   1);
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd11, 4'b0010, RB,   1);
    put(0, 0, 4'b0100, ASEQ, 4'b0100, 5'd11, 4'b0000, RB,   0); // grant 2
    put(1, 0, 4'b0000, ASEQ, 4'b0000, 5'd12, 4'b0000, RB,   1); // reset mid-flight
    put(0, 0, 4'b1111, ASEQ, 4'b0001, 5'd0,  4'b0000, 0,    0); // no resp, ptr=0
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd10, 4'b0000, 0,    1);
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd10, 4'b0001, RA,   1);
    put(0, 0, 4'b0000, ASEQ, 4'b0000, 5'd10, 4'b0000, RA,   0);
    put(0, 0, 4'b0001, AZ,   4'b0001, 5'd10, 4'b0000, RA,   0); // read register 0
    put(0, 0, 4'b0000, AZ,   4'b0000, 5'd0,  4'b0000, RA,   1);
    put(0, 0, 4'b0000, AZ,   4'b0000, 5'd0,  4'b0001, ZEXP, 1);

    rst = 1'b1; req = '0; addr = '0; stall = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      rst = vec[i].rst; stall = vec[i].stall; req = vec[i].req; addr = vec[i].addr;
      #1;
      check("ack",        i, 32'(ack),  32'(vec[i].ack));
      check("mux_select", i, 32'(sel),  32'(vec[i].sel));
      check("resp_valid", i, 32'(rv),   32'(vec[i].rv));
      check("resp_data",  i, rd,        vec[i].rd);
      check("busy",       i, 32'(busy), 32'(vec[i].busy));
      $display("vec %0d rst=%b stall=%b req=%b ack=%b sel=%0d rv=%b rd=%h busy=%b",
               i, rst, stall, req, ack, sel, rv, rd, busy);
    end

    // Rotation with every requester active: grants go 0,1,2,3,0,1,2,3
    @(negedge clk); rst = 1'b1; req = '0; stall = 1'b0; addr = ASEQ;
    @(negedge clk); rst = 1'b0; req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rotate_ack", k, 32'(ack), 32'(4'b0001 << (k % NREQ)));
      $display("rotate %0d ack=%b", k, ack);
      @(negedge clk);
    end
    req = '0;

    // Bounded wait for a lone requester, then exact two-cycle response latency
    @(negedge clk); req = 4'b1000;
    #1;
    waited = 0;
    while (ack !== 4'b1000 && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    check("ack_wait_cycles", 0, 32'(waited), 32'(0));
    $display("lone requester 3 ack=%b after %0d cycles", ack, waited);
    @(negedge clk); req = '0;
    #1;
    check("lat_t1_rv",   1, 32'(rv), 32'(4'b0000));
    check("lat_t1_sel",  1, 32'(sel), 32'(5'd13));
    @(negedge clk); #1;
    check("lat_t2_rv",   2, 32'(rv), 32'(4'b1000));
    check("lat_t2_data", 2, rd, RD);
    $display("latency check rv=%b rd=%h", rv, rd);
    @(negedge clk); #1;
    check("lat_t3_rv",   3, 32'(rv), 32'(4'b0000));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_read_port_arbiter.md
Name: regfile_read_port_arbiter

Overview:
- Round-robin arbiter that shares one register-file read port between NUM_REQ requesters.
- The read port is a 32-entry, 5-bit-select, BITS-wide mux; this block drives its select and captures its output.
- Sits between the register bank and its consumers (decode, debug, exception logic); issues at most one read per cycle, pipelined, full throughput.

Parameters:
- BITS, 32, data width of each register and of the mux output
- NUM_REQ, 4, number of requesters (2..8)

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RESET  input  1  synchronous, active-high reset
- REQ  input  NUM_REQ  per-requester read request; held high with ADDR stable until ACK
- ADDR  input  NUM_REQ x 5  per-requester register index
- STALL  input  1  blocks new grants (e.g. write in progress); in-flight reads still complete
- ACK  output  NUM_REQ  one-hot; combinational; request accepted this cycle
- MUX_SELECT  output  5  registered select to the 32:1 mux
- MUX_OUT  input  BITS  combinational mux output for the current MUX_SELECT
- RESP_VALID  output  NUM_REQ  one-hot registered pulse; RESP_DATA belongs to that requester
- RESP_DATA  output  BITS  registered read data
- BUSY  output  1  high while any read is in the two pipeline stages

Behaviour:
- Reset values (RESET high at an edge):
  - MUX_SELECT=0, RESP_VALID=0, RESP_DATA=0, BUSY=0.
  - Round-robin pointer PTR=0; stage-1 valid and owner cleared.
  - ACK forced to 0 in any cycle where RESET is high.
- Arbitration (cycle t):
  - If STALL=0 and REQ!=0, the winner is the first set REQ bit scanning PTR, PTR+1, ... with wrap modulo NUM_REQ.
  - ACK[winner]=1 in the same cycle; all other ACK bits 0.
  - If STALL=1 or REQ=0: ACK=0 and no state change in stage 0.
- Pointer: on a grant, PTR <= (winner+1) mod NUM_REQ. Without a grant, PTR holds.
- Pipeline:
  - Edge ending t: MUX_SELECT <= ADDR[winner]; S1_VALID <= 1; S1_OWNER <= winner.
  - Cycle t+1: MUX_OUT settles.
  - Edge ending t+1: RESP_DATA <= MUX_OUT; RESP_VALID <= one-hot(S1_OWNER) if S1_VALID, else 0.
  - Latency: ACK in cycle t, RESP_VALID/RESP_DATA in cycle t+2. Throughput: one grant per cycle.
  - With no new grant, MUX_SELECT holds its last value and S1_VALID <= 0.
- RESP_DATA holds its last value when RESP_VALID=0. RESP_VALID is a one-cycle pulse per grant.
- BUSY = S1_VALID OR (any RESP_VALID bit set).
- Boundary cases:
  - NUM_REQ wrap: PTR=NUM_REQ-1 with a grant to that requester sets PTR to 0.
  - All requesters active: grants rotate strictly; each requester waits at most NUM_REQ-1 cycles after its REQ rises.
  - STALL rising with a read in S1: that read still returns at its scheduled cycle.
  - STALL held: PTR frozen, no ACK.
  - RESET mid-operation: in-flight reads are discarded, no RESP_VALID after reset, PTR returns to 0.
  - A requester dropping REQ before ACK is legal; it is simply not granted.
  - ADDR is sampled only in the grant cycle.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined: a granted read with ADDR=0 returns RESP_DATA=0 regardless of MUX_OUT. Latency and handshake are unchanged; MUX_SELECT is still driven to 0.
- Undefined: address 0 returns MUX_OUT like any other index.

Test Plan:
- Single read: reset, REQ=4'b0001, ADDR[0]=5, MUX model returns reg[5]=32'hDEAD_BEEF -> ACK[0] in cycle 0, MUX_SELECT=5 in cycle 1, RESP_VALID=4'b0001 with RESP_DATA=32'hDEAD_BEEF in cycle 2, BUSY high in cycles 1-2.
- Full contention: REQ=4'b1111 held, ADDR[i]=i+10 -> ACK sequence 0,1,2,3,0,... one per cycle; RESP_VALID follows two cycles later in the same order with data reg[10..13].
- Wrap and fairness: PTR=3 after grants to 0..2, then REQ=4'b1001 -> grant 3, then 0; PTR ends at 1.
- Stall: REQ=4'b0010 with STALL=1 for 3 cycles -> ACK=0 and PTR unchanged for those cycles. A read granted the cycle before STALL still returns RESP_VALID two cycles after its ACK. STALL=0 -> ACK[1] the next cycle.
- Reset mid-flight: grant requester 2, assert RESET in cycle 1 -> no RESP_VALID in cycle 2, all outputs 0, PTR=0.
- REGFILE_ZERO_REG_EN defined: ADDR[0]=0 with MUX_OUT=32'hFFFF_FFFF -> RESP_DATA=0. Undefined: same stimulus -> RESP_DATA=32'hFFFF_FFFF.
